// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: sequences one FP instruction into the FPU, holds its result for writeback and keeps the sticky fflags
module fpu_issue_ctrl #(
  parameter int FLEN    = 32,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_op,
  input  logic [2:0]      req_funct3,
  input  logic [2:0]      req_rm,
  input  logic [FLEN-1:0] req_rs1,
  input  logic [FLEN-1:0] req_rs2,
  input  logic [FLEN-1:0] req_rs3,
  input  logic [XLEN-1:0] req_int,
  input  logic [4:0]      req_rd,
  input  logic            req_wr_int,
  input  logic [2:0]      frm,
  output logic            fpu_start,
  output logic [4:0]      fpu_op,
  output logic [2:0]      fpu_funct3,
  output logic [2:0]      fpu_rm,
  output logic [FLEN-1:0] fpu_a,
  output logic [FLEN-1:0] fpu_b,
  output logic [FLEN-1:0] fpu_c,
  output logic [XLEN-1:0] fpu_int,
  input  logic            fpu_busy,
  input  logic            fpu_done,
  input  logic [FLEN-1:0] fpu_fp_result,
  input  logic [XLEN-1:0] fpu_int_result,
  input  logic [4:0]      fpu_flags,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic            wb_is_int,
  output logic [FLEN-1:0] wb_fp_data,
  output logic [XLEN-1:0] wb_int_data,
  output logic [4:0]      wb_flags,
  output logic [4:0]      fflags,
  input  logic            fflags_wr_en,
  input  logic [4:0]      fflags_wr_data,
  output logic            illegal_rm,
  output logic            timeout
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [4:0]      r_op, r_rd, r_wb_flags, r_fflags;
  logic [2:0]      r_funct3, r_rm;
  logic [FLEN-1:0] r_a, r_b, r_c, r_wb_fp;
  logic [XLEN-1:0] r_int, r_wb_int;
  logic            r_is_int, r_illegal, r_timeout;
  logic [2:0]      w_rm;
  logic            w_rm_bad, w_accept, w_capture, w_commit, w_expire;
  logic            w_unused;

  // FPU busy carries no sequencing meaning here; only done matters
  assign w_unused = fpu_busy;
  assign w_rm     = (req_rm == 3'b111) ? frm : req_rm;
  assign w_rm_bad = (w_rm >= 3'b101);

  assign fpu_op      = r_op;
  assign fpu_funct3  = r_funct3;
  assign fpu_rm      = r_rm;
  assign fpu_a       = r_a;
  assign fpu_b       = r_b;
  assign fpu_c       = r_c;
  assign fpu_int     = r_int;
  assign wb_rd       = r_rd;
  assign wb_is_int   = r_is_int;
  assign wb_fp_data  = r_wb_fp;
  assign wb_int_data = r_wb_int;
  assign wb_flags    = r_wb_flags;
  assign fflags      = r_fflags;
  assign illegal_rm  = r_illegal;
  assign timeout     = r_timeout;

  // State register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;

  // Next state, handshake outputs and the per-cycle event strobes
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_commit  = 1'b0;
    w_expire  = 1'b0;
    req_ready = (r_state == IDLE);
    fpu_start = (r_state == ISSUE);
    wb_valid  = (r_state == HOLD);
    case (r_state)
      IDLE: begin
        w_accept = req_valid && !w_rm_bad;
        w_next   = w_accept ? ISSUE : IDLE;
      end
      ISSUE: begin
        w_capture = fpu_done;
        w_next    = fpu_done ? HOLD : WAIT;
      end
      WAIT: begin
        w_capture = fpu_done;
        w_expire  = !fpu_done && (r_cnt == CW'(TIMEOUT - 2));
        w_next    = fpu_done ? HOLD : (w_expire ? IDLE : WAIT);
      end
      HOLD: begin
        w_commit = wb_ready;
        w_next   = wb_ready ? IDLE : HOLD;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand/result latches, wait counter, sticky flags and status pulses
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_op       <= '0;
      r_funct3   <= '0;
      r_rm       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_int      <= '0;
      r_rd       <= '0;
      r_is_int   <= 1'b0;
      r_wb_fp    <= '0;
      r_wb_int   <= '0;
      r_wb_flags <= '0;
      r_fflags   <= '0;
      r_cnt      <= '0;
      r_illegal  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op     <= req_op;
        r_funct3 <= req_funct3;
        r_rm     <= w_rm;
        r_a      <= req_rs1;
        r_b      <= req_rs2;
        r_c      <= req_rs3;
        r_int    <= req_int;
        r_rd     <= req_rd;
        r_is_int <= req_wr_int;
      end
      if (w_capture) begin
        r_wb_fp    <= fpu_fp_result;
        r_wb_int   <= fpu_int_result;
        r_wb_flags <= fpu_flags;
      end
      r_cnt     <= (r_state == WAIT) ? r_cnt + CW'(1) : '0;
      r_fflags  <= (fflags_wr_en ? fflags_wr_data : r_fflags) | (w_commit ? r_wb_flags : 5'b0);
      r_illegal <= (r_state == IDLE) && req_valid && w_rm_bad;
      r_timeout <= w_expire;
    end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed checks of issue, wait, timeout, hold and fflags behaviour
module tb_fpu_issue_ctrl;
  logic        clk = 0, reset_n = 0;
  logic        req_valid = 0, req_ready, req_wr_int = 0;
  logic [4:0]  req_op = 0, req_rd = 0;
  logic [2:0]  req_funct3 = 0, req_rm = 0, frm = 0;
  logic [31:0] req_rs1 = 0, req_rs2 = 0, req_rs3 = 0, req_int = 0;
  logic        fpu_start, fpu_busy = 0, fpu_done = 0;
  logic [4:0]  fpu_op, fpu_flags = 0;
  logic [2:0]  fpu_funct3, fpu_rm;
  logic [31:0] fpu_a, fpu_b, fpu_c, fpu_int, fpu_fp_result = 0, fpu_int_result = 0;
  logic        wb_valid, wb_ready = 0, wb_is_int;
  logic [4:0]  wb_rd, wb_flags, fflags, fflags_wr_data = 0;
  logic [31:0] wb_fp_data, wb_int_data;
  logic        fflags_wr_en = 0, illegal_rm, timeout;
  int checks = 0, errors = 0, starts = 0;

  fpu_issue_ctrl #(.FLEN(32), .XLEN(32), .TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_funct3(req_funct3), .req_rm(req_rm),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3), .req_int(req_int),
    .req_rd(req_rd), .req_wr_int(req_wr_int), .frm(frm),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_funct3(fpu_funct3), .fpu_rm(fpu_rm),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c), .fpu_int(fpu_int),
    .fpu_busy(fpu_busy), .fpu_done(fpu_done), .fpu_fp_result(fpu_fp_result),
    .fpu_int_result(fpu_int_result), .fpu_flags(fpu_flags),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_is_int(wb_is_int),
    .wb_fp_data(wb_fp_data), .wb_int_data(wb_int_data), .wb_flags(wb_flags),
    .fflags(fflags), .fflags_wr_en(fflags_wr_en), .fflags_wr_data(fflags_wr_data),
    .illegal_rm(illegal_rm), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Count start pulses seen at active edges
  always @(posedge clk) if (fpu_start) starts <= starts + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [4:0] op, input logic [2:0] f3, input logic [2:0] rm,
                     input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd, input logic wi);
    req_op = op; req_funct3 = f3; req_rm = rm; req_rs1 = a; req_rs2 = b;
    req_rs3 = 32'h11112222; req_int = 32'h0000_0abc; req_rd = rd; req_wr_int = wi;
    req_valid = 1;
  endtask

  initial begin
    logic [31:0] sa, swb;
    logic        ok;
    tick(); tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_fflags", fflags, 0);
    chk("rst_fpu_start", fpu_start, 0);
    chk("rst_fpu_op", fpu_op, 0);
    chk("rst_pulses", {illegal_rm, timeout}, 0);
    reset_n = 1;
    tick();

    // FADD, done three cycles after start
    req(5'b00000, 3'b000, 3'b000, 32'h3F800000, 32'h40000000, 5'd3, 0);
    tick(); req_valid = 0;
    chk("fadd_start", fpu_start, 1);
    chk("fadd_ready_low", req_ready, 0);
    chk("fadd_a", fpu_a, 32'h3F800000);
    chk("fadd_b", fpu_b, 32'h40000000);
    chk("fadd_c", fpu_c, 32'h11112222);
    tick();
    chk("fadd_start_once", fpu_start, 0);
    tick();
    chk("fadd_no_wb_yet", wb_valid, 0);
    tick();
    fpu_done = 1; fpu_fp_result = 32'h40400000; fpu_flags = 0;
    tick();
    fpu_done = 0; fpu_fp_result = 32'hDEADBEEF;
    chk("fadd_wb_valid_t5", wb_valid, 1);
    chk("fadd_wb_data", wb_fp_data, 32'h40400000);
    chk("fadd_wb_is_int", wb_is_int, 0);
    chk("fadd_wb_rd", wb_rd, 3);
    chk("fadd_starts", starts, 1);
    wb_ready = 1;
    tick(); wb_ready = 0;
    chk("fadd_wb_drop", wb_valid, 0);
    chk("fadd_fflags", fflags, 0);

    // FEQ, done in the same cycle as start
    req(5'b01011, 3'b010, 3'b000, 32'h3F800000, 32'h3F800000, 5'd5, 1);
    tick(); req_valid = 0;
    chk("feq_start", fpu_start, 1);
    chk("feq_funct3", fpu_funct3, 3'b010);
    fpu_done = 1; fpu_int_result = 1; fpu_flags = 5'b10000;
    tick();
    fpu_done = 0; fpu_int_result = 0; fpu_flags = 0;
    chk("feq_wb_valid_t2", wb_valid, 1);
    chk("feq_wb_is_int", wb_is_int, 1);
    chk("feq_wb_int", wb_int_data, 1);
    chk("feq_wb_flags", wb_flags, 5'b10000);
    chk("feq_fflags_before", fflags, 0);
    wb_ready = 1;
    tick(); wb_ready = 0;
    chk("feq_fflags", fflags, 5'b10000);
    chk("feq_ready_next", req_ready, 1);

    // Dynamic rounding mode, legal then reserved
    frm = 3'b011;
    req(5'b00000, 3'b111, 3'b111, 32'h1, 32'h2, 5'd1, 0);
    tick(); req_valid = 0;
    chk("dyn_rm", fpu_rm, 3'b011);
    fpu_done = 1;
    tick(); fpu_done = 0; wb_ready = 1;
    tick(); wb_ready = 0;
    chk("dyn_fflags_kept", fflags, 5'b10000);
    frm = 3'b101;
    req(5'b00001, 3'b111, 3'b111, 32'h5, 32'h6, 5'd2, 0);
    tick(); req_valid = 0;
    chk("illegal_pulse", illegal_rm, 1);
    chk("illegal_ready", req_ready, 1);
    chk("illegal_no_start", fpu_start, 0);
    tick();
    chk("illegal_pulse_end", illegal_rm, 0);
    chk("illegal_no_latch", fpu_op, 5'b00000);
    chk("illegal_starts", starts, 3);
    frm = 3'b000;

    // FDIV that never completes
    req(5'b00011, 3'b000, 3'b001, 32'h40800000, 32'h0, 5'd7, 0);
    tick(); req_valid = 0;
    chk("fdiv_start", fpu_start, 1);
    ok = 1;
    for (int i = 1; i < 64; i++) begin
      tick();
      if (timeout || wb_valid || req_ready) ok = 0;
    end
    chk("fdiv_quiet_wait", ok, 1);
    tick();
    chk("fdiv_timeout_pulse", timeout, 1);
    chk("fdiv_idle", req_ready, 1);
    chk("fdiv_no_wb", wb_valid, 0);
    tick();
    chk("fdiv_timeout_end", timeout, 0);
    chk("fdiv_fflags", fflags, 5'b10000);

    // Stalled writeback, then CSR write colliding with commit
    req(5'b00001, 3'b000, 3'b010, 32'hC0000000, 32'h3F000000, 5'd9, 0);
    tick(); req_valid = 0;
    fpu_done = 1; fpu_fp_result = 32'hC0200000; fpu_flags = 5'b00001;
    tick();
    fpu_done = 0; fpu_fp_result = 0; fpu_flags = 0;
    sa = fpu_a; swb = wb_fp_data;
    chk("hold_wb_data", swb, 32'hC0200000);
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!wb_valid || req_ready || wb_fp_data !== swb || wb_flags !== 5'b00001 ||
          fpu_a !== sa || fpu_rm !== 3'b010 || wb_rd !== 5'd9) ok = 0;
    end
    chk("hold_stable", ok, 1);
    wb_ready = 1; fflags_wr_en = 1; fflags_wr_data = 5'b00100;
    tick(); wb_ready = 0; fflags_wr_en = 0;
    chk("csr_commit_or", fflags, 5'b00101);
    chk("hold_released", wb_valid, 0);

    // Reset while waiting, then a normal FMUL
    req(5'b00010, 3'b000, 3'b000, 32'h40000000, 32'h40400000, 5'd4, 0);
    tick(); req_valid = 0;
    tick(); tick();
    reset_n = 0;
    #1;
    chk("mid_rst_op", fpu_op, 0);
    chk("mid_rst_flags", fflags, 0);
    chk("mid_rst_ready", req_ready, 1);
    tick();
    chk("mid_rst_idle", {wb_valid, fpu_start, timeout, illegal_rm, wb_flags}, 0);
    reset_n = 1;
    tick();
    req(5'b00010, 3'b000, 3'b000, 32'h40000000, 32'h40400000, 5'd4, 0);
    tick(); req_valid = 0;
    chk("fmul_start", fpu_start, 1);
    chk("fmul_op", fpu_op, 5'b00010);
    tick();
    fpu_done = 1; fpu_fp_result = 32'h40C00000; fpu_flags = 5'b00001;
    tick();
    fpu_done = 0; fpu_flags = 0;
    chk("fmul_wb_valid", wb_valid, 1);
    chk("fmul_wb_data", wb_fp_data, 32'h40C00000);
    wb_ready = 1;
    tick(); wb_ready = 0;
    chk("fmul_fflags", fflags, 5'b00001);
    chk("total_starts", starts, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Sequencer directly upstream of the FPU datapath. It accepts one FP instruction at a time from the execute stage over a valid/ready handshake.
- It resolves the rounding mode, then drives the FPU's start/op/operand inputs from registered copies, which stay stable until done.
- It captures the FPU result and flags on done, presents them to writeback over a valid/ready handshake, and owns the sticky fflags accumulator feeding the CSR file.

Parameters:
- FLEN, 32, FP operand/result width (32 = F, 64 = D).
- XLEN, 32, integer operand/result width.
- TIMEOUT, 64, maximum cycles from start to done before abort; must be ≥ 2.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents an FP instruction
- req_ready  out  1  controller can accept a request
- req_op  in  5  FP ALU op encoding (ADD=00000 … MV_WX=10010)
- req_funct3  in  3  instruction funct3
- req_rm  in  3  instruction rm field
- req_rs1, req_rs2, req_rs3  in  FLEN  FP source operands
- req_int  in  XLEN  integer source operand
- req_rd  in  5  destination register index
- req_wr_int  in  1  destination is the integer register file
- frm  in  3  frm CSR value
- fpu_start  out  1  one-cycle start pulse
- fpu_op  out  5  registered op
- fpu_funct3  out  3  registered funct3
- fpu_rm  out  3  resolved rounding mode
- fpu_a, fpu_b, fpu_c  out  FLEN  registered operands
- fpu_int  out  XLEN  registered integer operand
- fpu_busy  in  1  FPU busy
- fpu_done  in  1  FPU done pulse; may be asserted combinationally in the same cycle as fpu_start
- fpu_fp_result  in  FLEN  FP result
- fpu_int_result  in  XLEN  integer result
- fpu_flags  in  5  {nv,dz,of,uf,nx}
- wb_valid  out  1  result held for writeback
- wb_ready  in  1  writeback consumes result
- wb_rd  out  5  destination index
- wb_is_int  out  1  integer destination
- wb_fp_data  out  FLEN  captured FP result
- wb_int_data  out  XLEN  captured integer result
- wb_flags  out  5  captured flags
- fflags  out  5  sticky accumulated flags
- fflags_wr_en  in  1  CSR write to fflags/fcsr
- fflags_wr_data  in  5  CSR write data
- illegal_rm  out  1  one-cycle pulse: request rejected for a reserved rounding mode
- timeout  out  1  one-cycle pulse: operation aborted

Behaviour:
- States: IDLE, ISSUE, WAIT, HOLD.
- Reset (asynchronous, reset_n=0):
  - state = IDLE.
  - All registered outputs clear to 0, including fflags, wb_*, fpu_start, illegal_rm, timeout.
  - Reset mid-operation discards the in-flight op; no writeback or flag update occurs.
- Rounding-mode resolution:
  - Effective rm = frm if req_rm == 111, else req_rm.
  - Effective rm of 101, 110 or 111 is illegal.
- IDLE:
  - req_ready = 1; it is 0 in every other state.
  - On req_valid with an illegal rm: pulse illegal_rm the next cycle, latch nothing, stay IDLE.
  - On req_valid with a legal rm: latch all req_* fields and the resolved rm into fpu_* / wb_rd / wb_is_int, then go to ISSUE.
- ISSUE (exactly one cycle):
  - fpu_start = 1.
  - If fpu_done is asserted this cycle: capture results and flags, go to HOLD.
  - Otherwise clear the counter and go to WAIT.
- WAIT:
  - fpu_start = 0; counter increments each cycle.
  - On fpu_done: capture and go to HOLD.
  - If the counter reaches TIMEOUT-1 without done: pulse timeout, go to IDLE with no writeback and no flag update.
  - fpu_busy is ignored for sequencing.
- Capture:
  - wb_fp_data ← fpu_fp_result, wb_int_data ← fpu_int_result, wb_flags ← fpu_flags, all in the cycle fpu_done is seen.
- HOLD:
  - wb_valid = 1; wb_* stay stable until wb_ready.
  - On wb_ready: commit and go to IDLE. wb_valid drops the next cycle.
- fpu_* stability: outputs stay constant from ISSUE until the controller leaves HOLD or WAIT, because the FPU output mux is combinational on the op.
- fflags update each cycle:
  - next = (fflags_wr_en ? fflags_wr_data : fflags) | (commit ? wb_flags : 0).
  - A simultaneous CSR write and commit yields the CSR data OR the committed flags.
- Latency:
  - Request accepted at cycle T, ISSUE at T+1.
  - Single-cycle op: wb_valid at T+2.
  - Op finishing N cycles after start: wb_valid at T+2+N.
  - Next request can be accepted one cycle after the wb handshake.

Test Plan:
- FADD (00000), rs1=0x3F800000, rs2=0x40000000, rm=000; FPU model gives done after 3 cycles with 0x40400000 and flags 0 -> one start pulse; wb_valid 5 cycles after accept; wb_fp_data=0x40400000; fflags stays 00000.
- FEQ (01011), funct3=010, FPU done same cycle as start, int_result=1, flags=10000 -> wb_valid at T+2, wb_is_int=1, wb_int_data=1; fflags=10000 after handshake.
- req_rm=111 with frm=011 -> fpu_rm=011. req_rm=111 with frm=101 -> illegal_rm pulse, no fpu_start, req_ready stays 1.
- FDIV with done never asserted, TIMEOUT=64 -> timeout pulse exactly 64 cycles after ISSUE; returns to IDLE; wb_valid never rises; fflags unchanged.
- wb_ready held 0 for 10 cycles in HOLD -> wb_* and fpu_* stable, req_ready=0. fflags_wr_en with data 00100 in the commit cycle where wb_flags=00001 -> fflags=00101.
- reset_n asserted during WAIT -> next cycle IDLE with all outputs 0. A following FMUL completes normally.
